fake_entropy_src: RTL and testbench
===================================

Name:
fake_entropy_src

Overview:
Parametrised simulation-only entropy source; supplies the trng mixer with deterministic pseudo-random words through the standard entropy valid/ack port, behind a small output FIFO paced by a programmable rate. Register interface allows seed, rate and fault injection, so benches can exercise back-pressure, discard and security_error paths. It provides NO real entropy and must never be synthesised into a product.

Parameters:
DATA_WIDTH, 32, entropy word width, 8..32; word = low DATA_WIDTH bits of generator state.
FIFO_DEPTH, 4, output buffer depth, power of two, 2..16.
SEED, 32'h00000001, LFSR reset value; 0 is replaced by 1.
RATE_RESET, 8'h00, reset value of RATE register (idle cycles between generated words).

Ports:
clk  in  1  clock; single clock domain.
reset  in  1  synchronous, active-high reset.
cs, we  in  1, 1  register access strobe and write enable.
address  in  8  register address.
write_data  in  32  register write data.
read_data  out  32  combinational read data, 0 when cs=0 or we=1.
error  out  1  combinational: cs=1 and address unmapped.
discard  in  1  flush FIFO.
test_mode  in  1  generate counter pattern instead of LFSR.
security_error  out  1  registered, = CTRL[1].
entropy_enabled  out  1  = CTRL[0].
entropy_data  out  DATA_WIDTH  FIFO head.
entropy_valid  out  1  FIFO not empty.
entropy_ack  in  1  pop head when valid.
debug  out  8  low byte of last pushed word, latched on debug_update.
debug_update  in  1  debug latch strobe.

Behaviour:
- Registers: 0x00 NAME RO 32'h66616b65; 0x08 CTRL RW {bit1 force_sec_error, bit0 enable}, reset 2'b01; 0x09 STATUS RO {fill[4:0] at bits 4:0, overflow sticky bit 8}; 0x0a SEED WO, write reloads LFSR next cycle; 0x0b RATE RW [7:0]; write to STATUS clears overflow. Write to RO/unmapped: ignored, error=1 same cycle.
- Reset: FIFO empty, entropy_valid 0, rate counter 0, LFSR=SEED, test counter 0, overflow 0, debug 8'h00, CTRL 2'b01, so entropy_enabled 1, security_error 0.
- Generator: 32-bit Galois LFSR, right shift, next = (s>>1) ^ (s[0] ? 32'h80200003 : 0). Generate event pushes current word then advances LFSR (or test counter +1 when test_mode).
- Pacing: when enable=1, rate counter increments each cycle; when counter==RATE, generate event fires and counter returns 0. RATE=0 -> one word per cycle. enable=0 holds counter and LFSR.
- Latency: push in cycle N -> entropy_valid high from cycle N+1. First word after reset (RATE=0) visible 1 cycle after reset deasserts.
- Handshake: pop when entropy_valid && entropy_ack; entropy_data then shows next entry next cycle. ack while empty ignored.
- Full: push when full and no pop -> word dropped, LFSR still advances, overflow set. Push+pop same cycle when full -> both succeed, no overflow.
- discard: FIFO emptied next cycle; any push or pop that cycle suppressed; LFSR still advances.
- SEED write with value 0 loads 1. SEED write concurrent with generate event: event uses old state, new seed wins.
- Reset mid-stream: all state returns to reset values in one cycle regardless of pending ack/discard.

Optional Feature:
FAKE_ENTROPY_STATS_EN: adds RO 32-bit counter at 0x0c of words delivered (pops), wraps at 2^32, cleared by reset or discard-free write to 0x0c. Without macro 0x0c is unmapped (error=1, read 0).

Decomposition:
Package fake_entropy_pkg: register addresses, NAME constant, LFSR taps 32'h80200003, CTRL bit indices. One sub-module: fake_entropy_fifo (parametrised sync FIFO with flush, fill count, full/empty).

Test Plan:
Reset, RATE=0, ack held 1 -> entropy_data sequence 32'h00000001, 32'h80200003, 32'hC0300002 on consecutive cycles.
ack held 0, RATE=0 -> valid after 1 cycle, STATUS fill reaches 4, then STATUS bit8=1; write STATUS -> bit8=0.
RATE=3, ack=1 -> one word accepted every 4 cycles; valid pulses high 1 of every 4.
FIFO full, pulse discard -> entropy_valid 0 next cycle, fill 0; refills next generate event.
test_mode=1 from reset -> words 0,1,2,3; write SEED 0 then test_mode=0 -> next words 1, 32'h80200003.
Write CTRL 2'b11 -> security_error 1 next cycle; read addr 0x40 with cs -> error=1, read_data 0; STATS_EN build: 5 acks -> 0x0c reads 5.

Source files
------------

// File: rtl/fake_entropy_pkg.sv
// Shared constants for the simulation-only fake entropy source: register map,
// identification word, LFSR taps and CTRL bit positions.
package fake_entropy_pkg;

  typedef enum logic [7:0] {
    ADDR_NAME   = 8'h00,
    ADDR_CTRL   = 8'h08,
    ADDR_STATUS = 8'h09,
    ADDR_SEED   = 8'h0a,
    ADDR_RATE   = 8'h0b,
    ADDR_STATS  = 8'h0c
  } reg_addr_e;

  localparam logic [31:0] NAME_VALUE   = 32'h66616b65;
  localparam logic [31:0] LFSR_TAPS    = 32'h80200003;
  localparam int unsigned CTRL_ENABLE  = 0;
  localparam int unsigned CTRL_SEC_ERR = 1;
  localparam logic [1:0]  CTRL_RESET   = 2'b01;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

  // An all-zero state would lock the LFSR, so zero seeds become 1.
  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return (s == '0) ? 32'd1 : s;
  endfunction

endpackage

// File: rtl/fake_entropy_src_if.sv
// Entropy valid/ack stream: master is the source, slave is the consumer.
interface fake_entropy_src_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] entropy_data;
  logic                  entropy_valid;
  logic                  entropy_ack;

  modport master (output entropy_data, output entropy_valid, input entropy_ack);
  modport slave  (input entropy_data, input entropy_valid, output entropy_ack);
endinterface

// File: rtl/fake_entropy_fifo.sv
// Synchronous FIFO with flush and fill count; DEPTH must be a power of two.
module fake_entropy_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd];
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush && !reset) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/fake_entropy_src.sv
// Simulation-only deterministic entropy source (LFSR or counter) behind a paced FIFO.
// Optional FAKE_ENTROPY_STATS_EN adds a delivered-word counter at 0x0c.
module fake_entropy_src
  import fake_entropy_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] SEED       = 32'h00000001,
  parameter logic [7:0]  RATE_RESET = 8'h00
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cs,
  input  logic                   we,
  input  logic [7:0]             address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   error,
  input  logic                   discard,
  input  logic                   test_mode,
  output logic                   security_error,
  output logic                   entropy_enabled,
  output logic [7:0]             debug,
  input  logic                   debug_update,
  fake_entropy_src_if.master     ent
);
  localparam logic [31:0] SEED_EFF = seed_fix(SEED);
  localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]            r_ctrl;
  logic [7:0]            r_rate;
  logic [7:0]            r_rate_cnt;
  logic [31:0]           r_lfsr;
  logic [31:0]           r_test_cnt;
  logic                  r_ovf;
  logic [7:0]            r_last_push;
  logic [7:0]            r_debug;

  logic                  w_gen;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_wr;
  logic [DATA_WIDTH-1:0] w_word;
  logic [CW-1:0]         w_count;
  logic                  w_full;
  logic                  w_empty;
  logic [31:0]           w_rdata;
  logic                  w_mapped;

  assign w_wr   = cs && we;
  assign w_gen  = r_ctrl[CTRL_ENABLE] && (r_rate_cnt == r_rate);
  assign w_push = w_gen && !discard;
  assign w_pop  = ent.entropy_valid && ent.entropy_ack && !discard;
  assign w_word = test_mode ? r_test_cnt[DATA_WIDTH-1:0] : r_lfsr[DATA_WIDTH-1:0];

  fake_entropy_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (discard),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_word),
    .o_data  (ent.entropy_data),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign ent.entropy_valid = !w_empty;
  assign security_error    = r_ctrl[CTRL_SEC_ERR];
  assign entropy_enabled   = r_ctrl[CTRL_ENABLE];
  assign debug             = r_debug;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl      <= CTRL_RESET;
      r_rate      <= RATE_RESET;
      r_rate_cnt  <= '0;
      r_lfsr      <= SEED_EFF;
      r_test_cnt  <= '0;
      r_ovf       <= 1'b0;
      r_last_push <= '0;
      r_debug     <= '0;
    end else begin
      if (r_ctrl[CTRL_ENABLE]) r_rate_cnt <= w_gen ? '0 : r_rate_cnt + 8'd1;
      // Seed write outranks the generator advance in the same cycle.
      if (w_wr && address == ADDR_SEED) r_lfsr <= seed_fix(write_data);
      else if (w_gen && !test_mode)     r_lfsr <= lfsr_next(r_lfsr);
      if (w_gen && test_mode) r_test_cnt <= r_test_cnt + 32'd1;
      if (w_wr && address == ADDR_CTRL) r_ctrl <= write_data[1:0];
      if (w_wr && address == ADDR_RATE) r_rate <= write_data[7:0];
      if (w_push && w_full && !w_pop)          r_ovf <= 1'b1;
      else if (w_wr && address == ADDR_STATUS) r_ovf <= 1'b0;
      if (w_push && (!w_full || w_pop)) r_last_push <= w_word[7:0];
      if (debug_update) r_debug <= r_last_push;
    end
  end

`ifdef FAKE_ENTROPY_STATS_EN
  logic [31:0] r_stats;

  always_ff @(posedge clk) begin
    if (reset)                            r_stats <= '0;
    else if (w_wr && address == ADDR_STATS) r_stats <= '0;
    else if (w_pop)                       r_stats <= r_stats + 32'd1;
  end
`endif

  always_comb begin
    w_rdata  = '0;
    w_mapped = 1'b1;
    case (address)
      ADDR_NAME:   w_rdata = NAME_VALUE;
      ADDR_CTRL:   w_rdata = {30'd0, r_ctrl};
      ADDR_STATUS: w_rdata = {23'd0, r_ovf, 3'd0, 5'(w_count)};
      ADDR_SEED:   w_rdata = '0;
      ADDR_RATE:   w_rdata = {24'd0, r_rate};
`ifdef FAKE_ENTROPY_STATS_EN
      ADDR_STATS:  w_rdata = r_stats;
`endif
      default:     w_mapped = 1'b0;
    endcase
  end

  assign read_data = (cs && !we) ? w_rdata : '0;
  assign error     = cs && (!w_mapped || (we && address == ADDR_NAME));

endmodule

// File: tb/tb_fake_entropy_src.sv
// Directed bench for fake_entropy_src with hand-computed LFSR/FIFO expectations.
module tb_fake_entropy_src;
  logic        clk = 1'b0;
  logic        reset;
  logic        cs, we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        error;
  logic        discard, test_mode;
  logic        security_error, entropy_enabled;
  logic [7:0]  debug;
  logic        debug_update;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] rd;
  logic        er;

  fake_entropy_src_if #(.DATA_WIDTH(32)) u_if ();

  fake_entropy_src #(
    .DATA_WIDTH (32),
    .FIFO_DEPTH (4),
    .SEED       (32'h00000001),
    .RATE_RESET (8'h00)
  ) u_dut (
    .clk             (clk),
    .reset           (reset),
    .cs              (cs),
    .we              (we),
    .address         (address),
    .write_data      (write_data),
    .read_data       (read_data),
    .error           (error),
    .discard         (discard),
    .test_mode       (test_mode),
    .security_error  (security_error),
    .entropy_enabled (entropy_enabled),
    .debug           (debug),
    .debug_update    (debug_update),
    .ent             (u_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_read(input logic [7:0] a, output logic [31:0] d, output logic e);
    cs = 1'b1; we = 1'b0; address = a;
    #1;
    d = read_data; e = error;
    cs = 1'b0;
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [31:0] d, output logic e);
    cs = 1'b1; we = 1'b1; address = a; write_data = d;
    #1;
    e = error;
    tick();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; discard = 1'b0; debug_update = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; we = 1'b0; address = '0; write_data = '0;
    discard = 1'b0; test_mode = 1'b0; debug_update = 1'b0;
    u_if.entropy_ack = 1'b1;

    // Reset state, then LFSR sequence with ack held high
    do_reset();
    check("rst_valid", 32'(u_if.entropy_valid), 32'd0);
    check("rst_enabled", 32'(entropy_enabled), 32'd1);
    check("rst_sec_err", 32'(security_error), 32'd0);
    check("rst_debug", 32'(debug), 32'h00);
    tick();
    check("seq0_valid", 32'(u_if.entropy_valid), 32'd1);
    check("seq0_data", u_if.entropy_data, 32'h00000001);
    tick();
    check("seq1_data", u_if.entropy_data, 32'h80200003);
    debug_update = 1'b1;
    tick();
    debug_update = 1'b0;
    check("seq2_data", u_if.entropy_data, 32'hC0300002);
    check("debug_latch", 32'(debug), 32'h03);

    // Back-pressure: fill, overflow, clear
    u_if.entropy_ack = 1'b0;
    do_reset();
    tick();
    check("bp_valid", 32'(u_if.entropy_valid), 32'd1);
    tick(); tick(); tick();
    reg_read(8'h09, rd, er);
    check("bp_fill4", rd, 32'h00000004);
    tick();
    reg_read(8'h09, rd, er);
    check("bp_ovf", rd, 32'h00000104);
    check("bp_head", u_if.entropy_data, 32'h00000001);
    reg_write(8'h08, 32'h0, er);
    check("bp_disabled", 32'(entropy_enabled), 32'd0);
    reg_write(8'h09, 32'h0, er);
    check("bp_status_wr_err", 32'(er), 32'd0);
    tick(); tick();
    reg_read(8'h09, rd, er);
    check("bp_ovf_clr", rd, 32'h00000004);

    // RATE=3 pacing
    u_if.entropy_ack = 1'b1;
    do_reset();
    reg_write(8'h0b, 32'h3, er);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rate_valid%0d", i), 32'(u_if.entropy_valid), (i % 4 == 0) ? 32'd1 : 32'd0);
      if (i == 0) check("rate_w0", u_if.entropy_data, 32'h00000001);
      if (i == 4) check("rate_w1", u_if.entropy_data, 32'h80200003);
      tick();
    end
    reg_read(8'h0b, rd, er);
    check("rate_rd", rd, 32'h3);

    // Discard from full
    u_if.entropy_ack = 1'b0;
    do_reset();
    tick(); tick(); tick(); tick();
    reg_read(8'h09, rd, er);
    check("dis_full", rd, 32'h00000004);
    discard = 1'b1;
    tick();
    discard = 1'b0;
    check("dis_valid", 32'(u_if.entropy_valid), 32'd0);
    reg_read(8'h09, rd, er);
    check("dis_fill0", rd, 32'h00000000);
    tick();
    check("dis_refill", 32'(u_if.entropy_valid), 32'd1);
    check("dis_word", u_if.entropy_data, 32'hD8360002);

    // Test mode counter, then SEED 0 reload
    u_if.entropy_ack = 1'b1;
    test_mode = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("tm_word%0d", i), u_if.entropy_data, 32'(i));
    end
    reg_write(8'h0a, 32'h0, er);
    check("seed_wr_err", 32'(er), 32'd0);
    test_mode = 1'b0;
    check("tm_word4", u_if.entropy_data, 32'd4);
    tick();
    check("seed0_w0", u_if.entropy_data, 32'h00000001);
    tick();
    check("seed0_w1", u_if.entropy_data, 32'h80200003);

    // Register map and security_error
    check("sec_before", 32'(security_error), 32'd0);
    reg_write(8'h08, 32'h3, er);
    check("sec_after", 32'(security_error), 32'd1);
    reg_read(8'h40, rd, er);
    check("unmapped_err", 32'(er), 32'd1);
    check("unmapped_data", rd, 32'h0);
    reg_read(8'h00, rd, er);
    check("name", rd, 32'h66616b65);
    check("name_err", 32'(er), 32'd0);
    reg_write(8'h00, 32'h12345678, er);
    check("name_wr_err", 32'(er), 32'd1);
    reg_read(8'h08, rd, er);
    check("ctrl_rd", rd, 32'h3);
    cs = 1'b1; we = 1'b1; address = 8'h08; #1;
    check("rd_gated_we", read_data, 32'h0);
    cs = 1'b0; we = 1'b0;

    // Reset mid-stream with ack and discard pending
    discard = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0; discard = 1'b0;
    check("mid_rst_valid", 32'(u_if.entropy_valid), 32'd0);
    check("mid_rst_sec", 32'(security_error), 32'd0);

    // Delivered-word counter
    u_if.entropy_ack = 1'b0;
    do_reset();
    tick(); tick();
    u_if.entropy_ack = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    u_if.entropy_ack = 1'b0;
    reg_read(8'h0c, rd, er);
`ifdef FAKE_ENTROPY_STATS_EN
    check("stats5", rd, 32'd5);
    check("stats_err", 32'(er), 32'd0);
    reg_write(8'h0c, 32'h0, er);
    reg_read(8'h0c, rd, er);
    check("stats_clr", rd, 32'd0);
`else
    check("stats_unmapped_err", 32'(er), 32'd1);
    check("stats_unmapped_data", rd, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
